// File: rtl/spell_debug_host.sv
// Host-side sequencer for the spell core's serial debug port: turns write/read/run commands
// into shift/load/dump/run cycle sequences. Optional wait-for-stop timeout: SPELL_DBG_TIMEOUT_EN.
module spell_debug_host #(
  parameter int unsigned SAMPLE_DELAY   = 2,
  parameter int unsigned RUN_HOLD       = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       dbg_shift_in,
  output logic       dbg_load,
  output logic       dbg_dump,
  output logic [1:0] dbg_reg_sel,
  output logic       dbg_run,
  output logic       dbg_step,
  input  logic       dbg_shift_out,
  input  logic       dbg_stop
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SHIFT   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_DUMP    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_RUN     = 3'd5;
  localparam logic [2:0] S_WAIT    = 3'd6;
  localparam logic [2:0] S_RESP    = 3'd7;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;

  localparam logic [3:0] CAP_WAIT = 4'(SAMPLE_DELAY - 1);
  localparam logic [3:0] RUN_LAST = 4'(RUN_HOLD - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [7:0] cap_q, cap_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] dly_cnt_q, dly_cnt_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       shift_in_q, shift_in_d;
  logic       load_q, load_d;
  logic       dump_q, dump_d;
  logic [1:0] reg_sel_q, reg_sel_d;
  logic       run_q, run_d;
  logic       step_q, step_d;

`ifdef SPELL_DBG_TIMEOUT_EN
  logic [23:0] to_cnt_q, to_cnt_d;
`endif

  // NOTE: every signal gets its hold/default value first, so no path through the case can
  // leave one unassigned and infer a latch; pulse outputs default low instead of holding.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    cap_d       = cap_q;
    bit_cnt_d   = bit_cnt_q;
    dly_cnt_d   = dly_cnt_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    shift_in_d  = 1'b0;
    load_d      = 1'b0;
    dump_d      = 1'b0;
    reg_sel_d   = reg_sel_q;
    run_d       = run_q;
    step_d      = step_q;
`ifdef SPELL_DBG_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          data_d      = cmd_data;
          reg_sel_d   = cmd_reg;
          bit_cnt_d   = 3'd0;
          cmd_ready_d = 1'b0;
`ifdef SPELL_DBG_TIMEOUT_EN
          to_cnt_d    = 24'd0;
`endif
          case (cmd_op)
            OP_WRITE: begin
              state_d    = S_SHIFT;
              shift_in_d = cmd_data[7];
            end
            OP_READ: begin
              state_d = S_DUMP;
              dump_d  = 1'b1;
            end
            OP_RUN: begin
              state_d   = S_RUN;
              run_d     = 1'b1;
              step_d    = cmd_data[0];
              dly_cnt_d = RUN_LAST;
            end
            default: begin
              state_d     = S_RESP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = 8'h00;
            end
          endcase
        end
      end

      // Outputs are registered, so each cycle presents the bit after the one now on the wire.
      S_SHIFT: begin
        if (bit_cnt_q == 3'd7) begin
          state_d = S_LOAD;
          load_d  = 1'b1;
        end else begin
          bit_cnt_d  = bit_cnt_q + 3'd1;
          shift_in_d = data_q[3'd6 - bit_cnt_q];
        end
      end

      S_LOAD: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = 8'h00;
      end

      S_DUMP: begin
        state_d   = S_CAPTURE;
        dly_cnt_d = CAP_WAIT;
      end

      S_CAPTURE: begin
        if (dly_cnt_q != 4'd0) begin
          dly_cnt_d = dly_cnt_q - 4'd1;
        end else begin
          cap_d     = {cap_q[6:0], dbg_shift_out};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = cap_d;
          end
        end
      end

      S_RUN: begin
        if (dly_cnt_q != 4'd0) begin
          dly_cnt_d = dly_cnt_q - 4'd1;
        end else begin
          run_d = 1'b0;
          if (data_q[1]) begin
            state_d = S_WAIT;
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = {7'b0, dbg_stop};
          end
        end
      end

      S_WAIT: begin
        if (dbg_stop) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 8'h01;
        end
`ifdef SPELL_DBG_TIMEOUT_EN
        else if (to_cnt_q == TIMEOUT_CYCLES - 24'd1) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 8'h02;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + 24'd1;
        end
`endif
      end

      S_RESP: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= 8'h00;
      cap_q       <= 8'h00;
      bit_cnt_q   <= 3'd0;
      dly_cnt_q   <= 4'd0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      shift_in_q  <= 1'b0;
      load_q      <= 1'b0;
      dump_q      <= 1'b0;
      reg_sel_q   <= 2'd0;
      run_q       <= 1'b0;
      step_q      <= 1'b0;
`ifdef SPELL_DBG_TIMEOUT_EN
      to_cnt_q    <= 24'd0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      bit_cnt_q   <= bit_cnt_d;
      dly_cnt_q   <= dly_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      shift_in_q  <= shift_in_d;
      load_q      <= load_d;
      dump_q      <= dump_d;
      reg_sel_q   <= reg_sel_d;
      run_q       <= run_d;
      step_q      <= step_d;
`ifdef SPELL_DBG_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign dbg_shift_in = shift_in_q;
  assign dbg_load     = load_q;
  assign dbg_dump     = dump_q;
  assign dbg_reg_sel  = reg_sel_q;
  assign dbg_run      = run_q;
  assign dbg_step     = step_q;

endmodule

// File: tb/tb_spell_debug_host.sv
// Scoreboard bench for spell_debug_host: a serial core model on the debug port, a register-array
// reference model predicting responses, and a monitor popping expectations on rsp_valid.
module tb_spell_debug_host;

  localparam int SD = 2;
  localparam int RH = 2;
`ifdef SPELL_DBG_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 1000000;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [1:0] cmd_reg = 2'd0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       dbg_shift_in, dbg_load, dbg_dump, dbg_run, dbg_step;
  logic [1:0] dbg_reg_sel;
  logic       dbg_shift_out;
  logic       stop_drv = 1'b0;

  spell_debug_host #(
    .SAMPLE_DELAY(SD),
    .RUN_HOLD(RH),
    .TIMEOUT_CYCLES(24'(TO))
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_reg(cmd_reg),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .dbg_shift_in(dbg_shift_in), .dbg_load(dbg_load), .dbg_dump(dbg_dump),
    .dbg_reg_sel(dbg_reg_sel), .dbg_run(dbg_run), .dbg_step(dbg_step),
    .dbg_shift_out(dbg_shift_out), .dbg_stop(stop_drv)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: continuous shift register, load/dump against its register file, and a
  // SD-1 stage pipeline from shift_reg[7] to shift_out.
  logic [7:0]  core_regs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0]  core_sr = 8'h00;
  logic [14:0] so_pipe = '0;
  always @(posedge clk) begin
    if (dbg_load) core_regs[dbg_reg_sel] <= core_sr;
    if (dbg_dump) core_sr <= core_regs[dbg_reg_sel];
    else          core_sr <= {core_sr[6:0], dbg_shift_in};
    so_pipe <= {so_pipe[13:0], core_sr[7]};
  end
  assign dbg_shift_out = so_pipe[SD-2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model and scoreboard
  typedef struct packed {
    logic [7:0]  data;
    logic [31:0] acc;
    logic [31:0] lat;
    logic        chk_lat;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] ref_regs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  int         n_writes = 0;
  int         rsp_cnt = 0;
  int         load_total = 0;
  int         both_cnt = 0;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (dbg_load) load_total++;
    if (dbg_load && dbg_dump) both_cnt++;
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_data %0h with nothing pending (cycle %0d)", rsp_data, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_data", {24'b0, rsp_data}, {24'b0, mon_e.data});
        if (mon_e.chk_lat) check("rsp_latency", cyc - mon_e.acc, mon_e.lat);
      end
      rsp_cnt++;
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL ready_timeout: got cmd_ready 0 for 200 cycles, required 1");
  endtask

  // Issue one command, predict its response, and watch the debug pins until it completes.
  // stop_at: cycle after accept at which dbg_stop rises (0 = never); stop_lvl: level otherwise.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] r, input logic [7:0] d,
                         input int stop_at, input bit stop_lvl, input bit junk);
    exp_t e;
    bit ok, got;
    int seen0, runs, loads, dumps;
    logic [7:0] sh;
    wait_ready(ok);
    if (!ok) return;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_reg   = r;
    cmd_data  = d;
    stop_drv  = (op == 2'd2 && d[1]) ? 1'b0 : stop_lvl;
    e.acc     = cyc;
    e.chk_lat = 1'b1;
    case (op)
      2'd0: begin e.data = 8'h00; e.lat = 10; ref_regs[r] = d; n_writes++; end
      2'd1: begin e.data = ref_regs[r]; e.lat = SD + 9; end
      2'd2: begin
        if (!d[1])           begin e.data = {7'b0, stop_lvl}; e.lat = RH + 1; end
        else if (stop_at > 0) begin e.data = 8'h01; e.lat = stop_at + 1; end
        else                 begin e.data = 8'h02; e.lat = RH + 1 + TO; end
      end
      default: begin e.data = 8'h00; e.lat = 0; e.chk_lat = 1'b0; end
    endcase
    sb_q.push_back(e);
    seen0 = rsp_cnt;
    runs = 0; loads = 0; dumps = 0; sh = 8'h00; got = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      cmd_valid = junk && (k <= 2);
      if (cmd_valid) begin
        cmd_op   = 2'($urandom_range(0, 3));
        cmd_reg  = 2'($urandom_range(0, 3));
        cmd_data = 8'($urandom);
      end
      if (k == 1) check("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
      if (k == 1 && op == 2'd2) check("dbg_step", {31'b0, dbg_step}, {31'b0, d[0]});
      if (k <= 8) sh = {sh[6:0], dbg_shift_in};
      if (k == 9 && op == 2'd0) begin
        check("load_at_9", {31'b0, dbg_load}, 32'd1);
        check("reg_sel_at_load", {30'b0, dbg_reg_sel}, {30'b0, r});
      end
      if (dbg_run)  runs++;
      if (dbg_load) loads++;
      if (dbg_dump) dumps++;
      if (k == stop_at) stop_drv = 1'b1;
      if (rsp_cnt != seen0 && k >= 4) begin
        got = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_missing: got no rsp_valid within 400 cycles for op %0d", op);
    end
    if (op == 2'd0) check("shift_in_seq", {24'b0, sh}, {24'b0, d});
    if (op == 2'd2) check("run_cycles", runs, RH);
    check("load_pulses", loads, (op == 2'd0) ? 1 : 0);
    check("dump_pulses", dumps, (op == 2'd1) ? 1 : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int seen;
    logic [1:0] op, r;
    logic [7:0] d;
    bit wait_en;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {15'b0, cmd_ready, rsp_valid, rsp_data, dbg_shift_in, dbg_load, dbg_dump,
           dbg_reg_sel, dbg_run, dbg_step},
          32'h10000);
    rst = 1'b0;

    // Directed cases
    run_cmd(2'd0, 2'd0, 8'hA5, 0, 1'b0, 1'b0);
    run_cmd(2'd1, 2'd0, 8'h00, 0, 1'b0, 1'b0);
    run_cmd(2'd0, 2'd1, 8'h07, 0, 1'b0, 1'b0);
    run_cmd(2'd1, 2'd1, 8'h00, 0, 1'b0, 1'b1);
    run_cmd(2'd0, 2'd0, 8'h3C, 0, 1'b0, 1'b0);
    run_cmd(2'd1, 2'd0, 8'h00, 0, 1'b0, 1'b0);
    run_cmd(2'd2, 2'd0, 8'h03, 50, 1'b0, 1'b0);
    run_cmd(2'd2, 2'd0, 8'h00, 0, 1'b1, 1'b0);
    run_cmd(2'd2, 2'd0, 8'h01, 0, 1'b0, 1'b1);
    run_cmd(2'd3, 2'd2, 8'hFF, 0, 1'b0, 1'b0);

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      r  = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      wait_en = (op == 2'd2) && d[1];
      run_cmd(op, r, d, wait_en ? int'($urandom_range(3, 20)) : 0,
              1'($urandom_range(0, 1)), (op != 2'd3) && ($urandom_range(0, 1) == 1));
    end

    // Reset during SHIFT bit 4 of a write: no load, no response, register unchanged
    run_cmd(2'd0, 2'd1, 8'h5A, 0, 1'b0, 1'b0);
    run_cmd(2'd1, 2'd1, 8'h00, 0, 1'b0, 1'b0);
    wait_ready(ok);
    if (ok) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'd0;
      cmd_reg   = 2'd1;
      cmd_data  = 8'hC3;
      @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        if (k == 1) cmd_valid = 1'b0;
        if (k == 5) rst = 1'b1;
      end
      @(negedge clk);
      check("mid_shift_reset_outputs",
            {15'b0, cmd_ready, rsp_valid, rsp_data, dbg_shift_in, dbg_load, dbg_dump,
             dbg_reg_sel, dbg_run, dbg_step},
            32'h10000);
      rst = 1'b0;
      repeat (20) @(negedge clk);
    end
    run_cmd(2'd1, 2'd1, 8'h00, 0, 1'b0, 1'b0);

    // Wait-for-stop with stop held low
`ifdef SPELL_DBG_TIMEOUT_EN
    run_cmd(2'd2, 2'd0, 8'h02, 0, 1'b0, 1'b0);
`else
    wait_ready(ok);
    if (ok) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'd2;
      cmd_reg   = 2'd0;
      cmd_data  = 8'h02;
      stop_drv  = 1'b0;
      seen      = rsp_cnt;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (10000) @(negedge clk);
      check("no_rsp_without_timeout", rsp_cnt, seen);
      check("still_busy_in_wait", {31'b0, cmd_ready}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("wait_abandoned_by_reset", {31'b0, cmd_ready}, 32'd1);
    end
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check("load_dump_overlap", both_cnt, 0);
    check("total_load_pulses", load_total, n_writes);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spell_debug_host.md
Name: spell_debug_host

Overview:
- Host-side controller for the spell core's serial debug port. It drives shift_in, load, dump, reg_sel, run and step, and samples shift_out.
- Turns parallel commands (write register, read register, run/step) into the exact cycle sequences the core's debug shift register expects.
- Sits in the test/bring-up harness, or in an on-chip debug bridge, next to the core.

Parameters:
- SAMPLE_DELAY, 2, cycles from the dump-pulse cycle to the first shift_out sample (bit 7). Range 2..15; covers the core's shift_reg→shift_out register stage plus any extra pad/sync stages.
- RUN_HOLD, 2, cycles dbg_run stays high per RUN command (≥2 guarantees the core sees a rising edge).
- TIMEOUT_CYCLES, 24'd1000000, wait-for-stop limit; used only when SPELL_DBG_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, shared with the core
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid&&cmd_ready at a clock edge
- cmd_op  in  2  0=WRITE_REG, 1=READ_REG, 2=RUN, 3=reserved (treated as NOP)
- cmd_reg  in  2  target register select: 0=PC, 1=SP, 2=EXEC, 3=STACK_TOP
- cmd_data  in  8  WRITE data; for RUN: bit0=step, bit1=wait_for_stop
- rsp_valid  out  1  one-cycle pulse on completion of every accepted command
- rsp_data  out  8  READ: register value; WRITE/NOP: 0; RUN: {6'b0, timed_out, stopped}
- dbg_shift_in  out  1  serial data to core, MSB first
- dbg_load  out  1  load pulse to core
- dbg_dump  out  1  dump pulse to core
- dbg_reg_sel  out  2  register select to core
- dbg_run  out  1  run request to core
- dbg_step  out  1  single-step flag to core
- dbg_shift_out  in  1  serial data from core
- dbg_stop  in  1  core stop/sleep status (uo_out[1])

Behaviour:
- All dbg_* outputs and rsp_* are registered. Reset value of every output: 0, except cmd_ready=1. State resets to IDLE; all counters and captured data clear.
- States: IDLE, SHIFT, LOAD, DUMP, CAPTURE, RUN, WAIT, RESP.
- Accept: latch op, reg and data. Latch dbg_reg_sel=cmd_reg and hold it until RESP.
- WRITE_REG:
  - SHIFT lasts 8 cycles; in cycle i (0..7) dbg_shift_in=data[7-i].
  - LOAD lasts 1 cycle: dbg_load=1, dbg_shift_in=0.
  - Then RESP. Accept to rsp_valid = 10 cycles.
  - A write to reg 2 also starts single-step execution in the core; a write to reg 3 pushes a value. The host does not special-case either.
- READ_REG:
  - DUMP lasts 1 cycle: dbg_dump=1.
  - CAPTURE: counter waits SAMPLE_DELAY-1 cycles. Then dbg_shift_out is sampled at 8 consecutive clock edges into an 8-bit register, MSB first.
  - Then RESP. Accept to rsp_valid = 1+SAMPLE_DELAY+8 cycles (11 at default).
  - dbg_shift_in=0 throughout.
- RUN:
  - dbg_step=data[0]; dbg_run=1 for RUN_HOLD cycles, then dbg_run=0.
  - If data[1]=0: go to RESP with stopped=dbg_stop sampled in the last RUN cycle.
  - If data[1]=1: go to WAIT until dbg_stop=1; that cycle, set stopped=1 and go to RESP.
  - dbg_step holds its value until the next RUN command.
- RESP: exactly 1 cycle; rsp_valid=1; then IDLE. rsp_data holds its value until the next RESP.
- dbg_load and dbg_dump are never high in the same cycle. Neither is high outside LOAD or DUMP.
- cmd_valid while busy is ignored; no queueing.
- Reset mid-operation abandons the sequence: no partial load pulse, no rsp_valid.
- Counters: 3-bit bit counter, 4-bit delay counter, 24-bit timeout counter. The timeout counter saturates and never wraps.

Optional Feature:
- SPELL_DBG_TIMEOUT_EN defined:
  - WAIT counts cycles; at TIMEOUT_CYCLES it exits to RESP with timed_out=1, stopped=0.
  - The counter clears on every accept.
- Not defined:
  - WAIT exits only on dbg_stop or rst; timed_out is always 0.
  - No timeout counter is synthesised.

Test Plan:
- WRITE_REG reg=0 data=8'hA5 against a core model → shift_in sequence 1,0,1,0,0,1,0,1; one dbg_load cycle with reg_sel=0; model PC=8'hA5; rsp_valid 10 cycles after accept, rsp_data=0.
- WRITE reg=1 8'h07, then READ_REG reg=1 with SAMPLE_DELAY=2 → exactly one dump pulse; rsp_data=8'h07 11 cycles after accept.
- SAMPLE_DELAY=4 (two extra sync flops in the model path), READ of PC=8'h3C → rsp_data=8'h3C at cycle 13.
- RUN data=2'b11 with the core model asserting stop 50 cycles later → dbg_run high exactly 2 cycles, dbg_step=1, rsp_data=8'h01 one cycle after stop.
- With SPELL_DBG_TIMEOUT_EN and TIMEOUT_CYCLES=100, RUN wait with stop held low → rsp_data=8'h02 after 100 WAIT cycles. Without the macro, no rsp_valid within 10000 cycles.
- rst asserted during SHIFT bit 4 of a WRITE → next cycle: all outputs 0, cmd_ready=1, no dbg_load or rsp_valid ever seen; a following READ returns the old register value.
